// File: rtl/writeback_regfile_if.sv
// MEM/WB-to-register-file bundle: write-back inputs, ID-stage read ports, forwarding and count outputs.
// The master modport drives the pipeline side; the slave modport is the register file.
interface writeback_regfile_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 32
);
    logic [DATA_WIDTH-1:0] MemReadDataIn;
    logic [DATA_WIDTH-1:0] ALUResultIn;
    logic [ADDR_WIDTH-1:0] RegRdIn;
    logic                  RegWriteIn;
    logic                  MemToRegIn;
    logic [ADDR_WIDTH-1:0] ReadReg1;
    logic [ADDR_WIDTH-1:0] ReadReg2;
    logic [DATA_WIDTH-1:0] ReadData1;
    logic [DATA_WIDTH-1:0] ReadData2;
    logic [DATA_WIDTH-1:0] WriteDataOut;
    logic [CNT_WIDTH-1:0]  WriteCount;

    modport master (
        output MemReadDataIn, ALUResultIn, RegRdIn, RegWriteIn, MemToRegIn, ReadReg1, ReadReg2,
        input  ReadData1, ReadData2, WriteDataOut, WriteCount
    );

    modport slave (
        input  MemReadDataIn, ALUResultIn, RegRdIn, RegWriteIn, MemToRegIn, ReadReg1, ReadReg2,
        output ReadData1, ReadData2, WriteDataOut, WriteCount
    );
endinterface

// File: rtl/writeback_regfile.sv
// Write-back mux plus 2R/1W register file (r0 hardwired to zero) with a committed-write counter.
// Optional macro REGFILE_BYPASS_EN: a read of the register being written returns the new value.
module writeback_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                Clk,
    input  logic                Reset,
    writeback_regfile_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [CNT_WIDTH-1:0]  count_q;
    logic [CNT_WIDTH-1:0]  count_d;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  commit;

    assign wb_data = bus.MemToRegIn ? bus.MemReadDataIn : bus.ALUResultIn;
    assign commit  = bus.RegWriteIn && (bus.RegRdIn != '0);
    assign count_d = count_q + CNT_WIDTH'(1);

    // NOTE: the whole file sits in the async reset because ID must read zeros the moment
    // Reset asserts; this forces flops rather than a RAM macro, which is intended here.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            count_q <= '0;
        end else if (commit) begin
            regs_q[bus.RegRdIn] <= wb_data;
            count_q             <= count_d;
        end
    end

    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] idx);
        if (idx == '0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (commit && (idx == bus.RegRdIn)) return wb_data;
`endif
        return regs_q[idx];
    endfunction

    assign bus.ReadData1    = read_port(bus.ReadReg1);
    assign bus.ReadData2    = read_port(bus.ReadReg2);
    assign bus.WriteDataOut = wb_data;
    assign bus.WriteCount   = count_q;
endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: reset, commit, r0 discard, read-during-write,
// asynchronous reset mid-cycle, and counter wrap on a second instance with CNT_WIDTH=4.
module tb_writeback_regfile;
    logic clk;
    logic rst_n;
    int   n_compared = 0;
    int   n_mismatch = 0;

`ifdef REGFILE_BYPASS_EN
    localparam logic [31:0] R7_PRE_EDGE = 32'hA5A5_A5A5;
`else
    localparam logic [31:0] R7_PRE_EDGE = 32'h0000_0001;
`endif

    writeback_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(32)) bus ();
    writeback_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(4))  sbus ();

    writeback_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(32)) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus.slave)
    );

    writeback_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(4)) dut_small (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (sbus.slave)
    );

    // The narrow-counter instance sees exactly the same write-back traffic.
    assign sbus.MemReadDataIn = bus.MemReadDataIn;
    assign sbus.ALUResultIn   = bus.ALUResultIn;
    assign sbus.RegRdIn       = bus.RegRdIn;
    assign sbus.RegWriteIn    = bus.RegWriteIn;
    assign sbus.MemToRegIn    = bus.MemToRegIn;
    assign sbus.ReadReg1      = bus.ReadReg1;
    assign sbus.ReadReg2      = bus.ReadReg2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatch++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one write for a single rising edge, then withdraw it.
    task automatic commit_one(input logic [4:0] rd, input logic mem2reg, input logic [31:0] val);
        bus.RegWriteIn = 1'b1;
        bus.RegRdIn    = rd;
        bus.MemToRegIn = mem2reg;
        if (mem2reg) begin
            bus.MemReadDataIn = val;
            bus.ALUResultIn   = ~val;
        end else begin
            bus.ALUResultIn   = val;
            bus.MemReadDataIn = ~val;
        end
        @(posedge clk);
        #1;
        bus.RegWriteIn = 1'b0;
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.MemReadDataIn = '0;
        bus.ALUResultIn   = '0;
        bus.RegRdIn       = '0;
        bus.RegWriteIn    = 1'b0;
        bus.MemToRegIn    = 1'b0;
        bus.ReadReg1      = '0;
        bus.ReadReg2      = '0;

        // 1. Reset for two cycles, then every index reads zero.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_count", 64'(bus.WriteCount), 64'd0);
        check("reset_count_small", 64'(sbus.WriteCount), 64'd0);
        for (int i = 0; i < 32; i++) begin
            bus.ReadReg1 = 5'(i);
            bus.ReadReg2 = 5'(31 - i);
            #1;
            check($sformatf("reset_rd1_r%0d", i), 64'(bus.ReadData1), 64'd0);
            check($sformatf("reset_rd2_r%0d", 31 - i), 64'(bus.ReadData2), 64'd0);
        end

        // 2. ALU result committed to r5.
        @(negedge clk);
        bus.RegWriteIn  = 1'b1;
        bus.RegRdIn     = 5'd5;
        bus.MemToRegIn  = 1'b0;
        bus.ALUResultIn = 32'h1234_5678;
        bus.MemReadDataIn = 32'h0BAD_F00D;
        #1;
        check("wbmux_alu", 64'(bus.WriteDataOut), 64'h1234_5678);
        @(posedge clk);
        #1;
        bus.RegWriteIn = 1'b0;
        bus.ReadReg1   = 5'd5;
        #1;
        check("r5_after_write", 64'(bus.ReadData1), 64'h1234_5678);
        check("count_after_r5", 64'(bus.WriteCount), 64'd1);

        // 3. Load data aimed at r0 is discarded and not counted.
        @(negedge clk);
        bus.RegWriteIn    = 1'b1;
        bus.RegRdIn       = 5'd0;
        bus.MemToRegIn    = 1'b1;
        bus.MemReadDataIn = 32'hDEAD_BEEF;
        #1;
        check("wbmux_mem", 64'(bus.WriteDataOut), 64'hDEAD_BEEF);
        @(posedge clk);
        #1;
        bus.RegWriteIn = 1'b0;
        bus.ReadReg1   = 5'd0;
        bus.ReadReg2   = 5'd5;
        #1;
        check("r0_stays_zero", 64'(bus.ReadData1), 64'd0);
        check("r5_unchanged", 64'(bus.ReadData2), 64'h1234_5678);
        check("count_r0_ignored", 64'(bus.WriteCount), 64'd1);

        // RegWriteIn low: nothing stored, nothing counted.
        @(negedge clk);
        bus.RegRdIn     = 5'd6;
        bus.MemToRegIn  = 1'b0;
        bus.ALUResultIn = 32'h6666_6666;
        @(posedge clk);
        #1;
        bus.ReadReg1 = 5'd6;
        #1;
        check("r6_no_we", 64'(bus.ReadData1), 64'd0);
        check("count_no_we", 64'(bus.WriteCount), 64'd1);

        // 4. Read-during-write on r7 from both ports.
        @(negedge clk);
        commit_one(5'd7, 1'b0, 32'h0000_0001);
        check("count_after_r7", 64'(bus.WriteCount), 64'd2);
        @(negedge clk);
        bus.RegWriteIn    = 1'b1;
        bus.RegRdIn       = 5'd7;
        bus.MemToRegIn    = 1'b1;
        bus.MemReadDataIn = 32'hA5A5_A5A5;
        bus.ReadReg1      = 5'd7;
        bus.ReadReg2      = 5'd7;
        #1;
        check("rdw_rd1_pre", 64'(bus.ReadData1), 64'(R7_PRE_EDGE));
        check("rdw_rd2_pre", 64'(bus.ReadData2), 64'(R7_PRE_EDGE));
        @(posedge clk);
        #1;
        bus.RegWriteIn = 1'b0;
        #1;
        check("rdw_rd1_post", 64'(bus.ReadData1), 64'hA5A5_A5A5);
        check("rdw_rd2_post", 64'(bus.ReadData2), 64'hA5A5_A5A5);
        check("count_after_rdw", 64'(bus.WriteCount), 64'd3);

        // 5. Asynchronous reset asserted between edges with a write pending.
        @(negedge clk);
        commit_one(5'd3, 1'b0, 32'h0000_00FF);
        bus.ReadReg1 = 5'd3;
        #1;
        check("r3_written", 64'(bus.ReadData1), 64'hFF);
        check("count_before_rst", 64'(bus.WriteCount), 64'd4);
        bus.RegWriteIn  = 1'b1;
        bus.RegRdIn     = 5'd3;
        bus.MemToRegIn  = 1'b0;
        bus.ALUResultIn = 32'h0000_0077;
        #1;
        rst_n = 1'b0;
        #1;
        check("async_r3_zero", 64'(bus.ReadData1), 64'd0);
        check("async_count_zero", 64'(bus.WriteCount), 64'd0);
        @(posedge clk);
        #1;
        check("rst_write_dropped", 64'(bus.ReadData1), 64'd0);
        check("rst_count_held", 64'(bus.WriteCount), 64'd0);
        bus.RegWriteIn = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_r3", 64'(bus.ReadData1), 64'd0);
        check("post_rst_r7", 64'(bus.ReadData2), 64'd0);

        // 6. Seventeen commits to r1: the 4-bit counter wraps 15 -> 0 -> 1.
        bus.ReadReg1 = 5'd1;
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            commit_one(5'd1, i[0], 32'h1000_0000 + 32'(i));
            if (i == 15) check("small_count_15", 64'(sbus.WriteCount), 64'd15);
            if (i == 16) check("small_count_wrap", 64'(sbus.WriteCount), 64'd0);
        end
        #1;
        check("small_count_17", 64'(sbus.WriteCount), 64'd1);
        check("count_17", 64'(bus.WriteCount), 64'd17);
        check("r1_last", 64'(bus.ReadData1), 64'h1000_0011);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end
endmodule
